// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine.
// A 128-bit state is captured on handshake, then BYTES_PER_CYCLE bytes per
// cycle are replaced by their inverse S-box value (composite-field
// GF((2^4)^2) datapath) in ascending byte order. The finished state is held
// on out_state until the consumer takes it.
module inv_sub_bytes_iter #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   // Only divisors of 16 give an integral number of groups per state
   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
      $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam int         GROUPS    = 16 / BYTES_PER_CYCLE;
   localparam int         GW        = 8 * BYTES_PER_CYCLE;
   localparam logic [3:0] CNT_STEP  = 4'(BYTES_PER_CYCLE);
   localparam logic [3:0] CNT_LAST  = 4'(16 - BYTES_PER_CYCLE);
   localparam logic [3:0] LAMBDA    = 4'b1100;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [3:0]      cnt;
   logic [127:0]    work;
   logic [GW-1:0]   group_in;
   logic [GW-1:0]   group_out;

   // ---------------- GF(2^2) arithmetic, polynomial x^2 + x + 1 ----------------
   function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
      return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]),
              (a[1] & b[1]) ^ (a[0] & b[0])};
   endfunction

   // multiply by phi = {10}
   function automatic logic [1:0] gf2_mul_phi(input logic [1:0] a);
      return {a[1] ^ a[0], a[1]};
   endfunction

   // squaring; in GF(2^2) this is also the multiplicative inverse
   function automatic logic [1:0] gf2_sq(input logic [1:0] a);
      return {a[1], a[1] ^ a[0]};
   endfunction

   // ---------------- GF(2^4) = GF(2^2)[y] / (y^2 + y + phi) ----------------
   function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] hh;
      logic [1:0] ll;
      logic [1:0] ss;
      hh = gf2_mul(a[3:2], b[3:2]);
      ll = gf2_mul(a[1:0], b[1:0]);
      ss = gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
      return {ss ^ ll, gf2_mul_phi(hh) ^ ll};
   endfunction

   function automatic logic [3:0] gf4_inv(input logic [3:0] a);
      logic [1:0] d;
      logic [1:0] di;
      d  = gf2_mul_phi(gf2_sq(a[3:2])) ^ gf2_mul(a[3:2], a[1:0]) ^ gf2_sq(a[1:0]);
      di = gf2_sq(d);
      return {gf2_mul(a[3:2], di), gf2_mul(a[3:2] ^ a[1:0], di)};
   endfunction

   // ---------------- GF((2^4)^2) = GF(2^4)[z] / (z^2 + z + lambda) ----------------
   function automatic logic [7:0] gf8_inv(input logic [7:0] a);
      logic [3:0] d;
      logic [3:0] di;
      d  = gf4_mul(gf4_mul(a[7:4], a[7:4]), LAMBDA) ^ gf4_mul(a[7:4], a[3:0]) ^
           gf4_mul(a[3:0], a[3:0]);
      di = gf4_inv(d);
      return {gf4_mul(a[7:4], di), gf4_mul(a[7:4] ^ a[3:0], di)};
   endfunction

   // isomorphism from the AES polynomial basis into the composite basis
   function automatic logic [7:0] iso(input logic [7:0] a);
      return {a[7] ^ a[5],
              a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[7] ^ a[5] ^ a[3] ^ a[2],
              a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1],
              a[7] ^ a[6] ^ a[2] ^ a[1],
              a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[6] ^ a[4] ^ a[1],
              a[6] ^ a[1] ^ a[0]};
   endfunction

   // isomorphism back from the composite basis
   function automatic logic [7:0] iso_inv(input logic [7:0] a);
      return {a[7] ^ a[6] ^ a[5] ^ a[1],
              a[6] ^ a[2],
              a[6] ^ a[5] ^ a[1],
              a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[1],
              a[5] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
              a[5] ^ a[4],
              a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[0]};
   endfunction

   // inverse of the AES affine transform
   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return iso_inv(gf8_inv(iso(inv_affine(b))));
   endfunction

   // one inverse S-box per byte lane of the active group
   for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
      assign group_out[8*k +: 8] = inv_sbox(group_in[8*k +: 8]);
   end

   // select the group of the working register addressed by the byte counter
   always_comb begin
      group_in = '0;
      for (int g = 0; g < GROUPS; g++) begin
         if (cnt == 4'(g * BYTES_PER_CYCLE)) begin
            group_in = work[g*GW +: GW];
         end
      end
   end

   // next-state logic of the IDLE / RUN / DONE controller
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (cnt == CNT_LAST) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // state register, byte counter and working register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         work  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work <= in_state;
                  cnt  <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + CNT_STEP;
               for (int g = 0; g < GROUPS; g++) begin
                  if (cnt == 4'(g * BYTES_PER_CYCLE)) begin
                     work[g*GW +: GW] <= group_out;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_state = work;

endmodule
